// File: rtl/sar_adc_ctrl.sv
// sar_adc_ctrl: successive-approximation ADC controller.
// Drives the track/hold and DAC trial code, consumes the comparator
// decision and reports a WIDTH-bit result with a start/busy/done handshake.
// Optional macro SAR_ADC_CTRL_CMP_SYNC_EN: passes cmp_in through a 2-flop
// synchronizer and lengthens each settle phase by two cycles to cover it.
module sar_adc_ctrl #(
  parameter int WIDTH         = 8,
  parameter int SAMPLE_CYCLES = 4,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             cmp_in,
  output logic             sample,
  output logic [WIDTH-1:0] dac_code,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

`ifdef SAR_ADC_CTRL_CMP_SYNC_EN
  localparam int SETTLE_LEN = SETTLE_CYCLES + 2;
`else
  localparam int SETTLE_LEN = SETTLE_CYCLES;
`endif
  localparam int SETTLE_LOAD = (SETTLE_LEN > 0) ? SETTLE_LEN - 1 : 0;
  localparam int CNT_MAX     = (SAMPLE_CYCLES > SETTLE_LEN) ? SAMPLE_CYCLES : SETTLE_LEN;
  localparam int CNT_W       = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int K_W         = $clog2(WIDTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SAMPLE,
    S_SETTLE,
    S_COMPARE,
    S_DONE
  } state_t;

  state_t           state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic [K_W-1:0]   k, k_next;
  logic [WIDTH-1:0] code, code_next;
  logic [WIDTH-1:0] decided;
  logic [WIDTH-1:0] result_next;
  logic             cmp_bit;

`ifdef SAR_ADC_CTRL_CMP_SYNC_EN
  logic [1:0] cmp_sync;

  // Two-flop synchronizer for the asynchronous comparator decision
  always_ff @(posedge clk) begin
    if (rst) begin
      cmp_sync <= 2'b00;
    end else begin
      cmp_sync <= {cmp_sync[0], cmp_in};
    end
  end

  assign cmp_bit = cmp_sync[1];
`else
  assign cmp_bit = cmp_in;
`endif

  // State and datapath registers; reset discards any partial conversion
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      cnt    <= '0;
      k      <= '0;
      code   <= '0;
      result <= '0;
    end else begin
      state  <= state_next;
      cnt    <= cnt_next;
      k      <= k_next;
      code   <= code_next;
      result <= result_next;
    end
  end

  // Next-state, datapath updates and Moore outputs of the SAR sequencer
  always_comb begin
    state_next  = state;
    cnt_next    = cnt;
    k_next      = k;
    code_next   = code;
    result_next = result;
    decided     = code;
    sample      = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    dac_code    = '0;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_next = S_SAMPLE;
          cnt_next   = CNT_W'(SAMPLE_CYCLES - 1);
        end
      end
      S_SAMPLE: begin
        sample = 1'b1;
        busy   = 1'b1;
        if (cnt == '0) begin
          k_next               = K_W'(WIDTH - 1);
          code_next            = '0;
          code_next[WIDTH-1]   = 1'b1;
          if (SETTLE_LEN == 0) begin
            state_next = S_COMPARE;
          end else begin
            state_next = S_SETTLE;
            cnt_next   = CNT_W'(SETTLE_LOAD);
          end
        end else begin
          cnt_next = cnt - CNT_W'(1);
        end
      end
      S_SETTLE: begin
        busy     = 1'b1;
        dac_code = code;
        if (cnt == '0) begin
          state_next = S_COMPARE;
        end else begin
          cnt_next = cnt - CNT_W'(1);
        end
      end
      S_COMPARE: begin
        busy       = 1'b1;
        dac_code   = code;
        decided[k] = cmp_bit;
        code_next  = decided;
        if (k != '0) begin
          code_next[k - K_W'(1)] = 1'b1;
          k_next                 = k - K_W'(1);
          if (SETTLE_LEN == 0) begin
            state_next = S_COMPARE;
          end else begin
            state_next = S_SETTLE;
            cnt_next   = CNT_W'(SETTLE_LOAD);
          end
        end else begin
          result_next = decided;
          state_next  = S_DONE;
        end
      end
      S_DONE: begin
        done       = 1'b1;
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_sar_adc_ctrl.sv
// tb_sar_adc_ctrl: scoreboard bench for sar_adc_ctrl with an ideal
// comparator model; also exercises a WIDTH=4, SETTLE_CYCLES=0 instance.
module tb_sar_adc_ctrl;

`ifdef SAR_ADC_CTRL_CMP_SYNC_EN
  localparam int SET_EFF   = 4;
  localparam int SMALL_SET = 2;
`else
  localparam int SET_EFF   = 2;
  localparam int SMALL_SET = 0;
`endif
  localparam int L8 = 4 + 8 * (SET_EFF + 1) + 1;
  localparam int L4 = 4 + 4 * (SMALL_SET + 1) + 1;

  logic       clk = 1'b0;
  logic       rst, start, cmp_in;
  logic       sample, busy, done;
  logic [7:0] dac_code, result;
  logic [7:0] vin;
  int         cmp_mode;

  logic       start_s, cmp_s, sample_s, busy_s, done_s;
  logic [3:0] dac_s, result_s, vin_s;

  int         compared = 0;
  int         mismatched = 0;
  int         done_count = 0;
  logic [7:0] exp_q[$];
  logic [7:0] trace_q[$];

  assign cmp_in = (cmp_mode == 1) ? 1'b1 : (cmp_mode == 2) ? 1'b0 : (vin >= dac_code);
  assign cmp_s  = (vin_s >= dac_s);

  sar_adc_ctrl #(.WIDTH(8), .SAMPLE_CYCLES(4), .SETTLE_CYCLES(2)) dut (
    .clk(clk), .rst(rst), .start(start), .cmp_in(cmp_in), .sample(sample),
    .dac_code(dac_code), .busy(busy), .done(done), .result(result)
  );

  sar_adc_ctrl #(.WIDTH(4), .SAMPLE_CYCLES(4), .SETTLE_CYCLES(0)) dut_small (
    .clk(clk), .rst(rst), .start(start_s), .cmp_in(cmp_s), .sample(sample_s),
    .dac_code(dac_s), .busy(busy_s), .done(done_s), .result(result_s)
  );

  // Free-running clock
  initial forever #5 clk = ~clk;

  // Count every done pulse of the main instance
  always @(negedge clk) begin
    if (done === 1'b1) done_count++;
  end

  // Launch one conversion and run until done or a cycle budget expires
  task automatic run_conv(input logic [7:0] v, input int mode, output int lat,
                          output int busy_n, output int sample_n);
    logic [7:0] last;
    vin = v; cmp_mode = mode; trace_q.delete(); last = 8'h00;
    lat = 0; busy_n = 0; sample_n = 0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int n = 1; n <= 200; n++) begin
      busy_n += int'(busy);
      sample_n += int'(sample);
      if (dac_code != 8'h00 && dac_code != last) begin
        trace_q.push_back(dac_code);
        last = dac_code;
      end
      if (done === 1'b1) begin
        lat = n;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; start_s = 1'b0;
    repeat (3) @(negedge clk);
    compared++;
    if (sample !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_sample: got %b expected 0", sample); end
    compared++;
    if (dac_code !== 8'h00) begin mismatched++; $display("[TB] FAIL reset_dac: got %h expected 00", dac_code); end
    compared++;
    if (busy !== 1'b0 || done !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_busy_done: got %b%b expected 00", busy, done); end
    compared++;
    if (result !== 8'h00) begin mismatched++; $display("[TB] FAIL reset_result: got %h expected 00", result); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_ideal(input logic [7:0] v);
    int lat, busy_n, sample_n;
    logic [7:0] t, trial, exp;
    logic [7:0] exp_tr[8];
    bit tr_ok;
    t = 8'h00;
    for (int b = 7; b >= 0; b--) begin
      trial = t | (8'h01 << b);
      exp_tr[7-b] = trial;
      if (v >= trial) t = trial;
    end
    exp_q.push_back(v);
    run_conv(v, 0, lat, busy_n, sample_n);
    compared++;
    if (lat != L8) begin mismatched++; $display("[TB] FAIL ideal_latency: got %0d expected %0d", lat, L8); end
    compared++;
    if (sample_n != 4) begin mismatched++; $display("[TB] FAIL ideal_sample_cycles: got %0d expected 4", sample_n); end
    compared++;
    if (busy_n != L8 - 1) begin mismatched++; $display("[TB] FAIL ideal_busy_cycles: got %0d expected %0d", busy_n, L8 - 1); end
    tr_ok = (trace_q.size() == 8);
    for (int i = 0; i < 8 && tr_ok; i++) if (trace_q[i] !== exp_tr[i]) tr_ok = 0;
    compared++;
    if (!tr_ok) begin mismatched++; $display("[TB] FAIL ideal_dac_trace: got %0d codes first %h expected 8 codes first %h", trace_q.size(), (trace_q.size() > 0) ? trace_q[0] : 8'h00, exp_tr[0]); end
    exp = exp_q.pop_front();
    compared++;
    if (result !== exp) begin mismatched++; $display("[TB] FAIL ideal_result: got %h expected %h", result, exp); end
    @(negedge clk);
    compared++;
    if (done !== 1'b0) begin mismatched++; $display("[TB] FAIL ideal_done_width: got %b expected 0", done); end
  endtask

  task automatic test_tied(input int mode, input logic [7:0] expv);
    int lat, busy_n, sample_n;
    logic [7:0] exp;
    exp_q.push_back(expv);
    run_conv(8'h00, mode, lat, busy_n, sample_n);
    compared++;
    if (busy_n != L8 - 1 || lat != L8) begin mismatched++; $display("[TB] FAIL tied_busy: got busy %0d lat %0d expected %0d %0d", busy_n, lat, L8 - 1, L8); end
    exp = exp_q.pop_front();
    compared++;
    if (result !== exp) begin mismatched++; $display("[TB] FAIL tied_result: got %h expected %h", result, exp); end
    @(negedge clk);
    compared++;
    if (done !== 1'b0) begin mismatched++; $display("[TB] FAIL tied_done_width: got %b expected 0", done); end
    cmp_mode = 0;
  endtask

  task automatic test_start_during_busy();
    int d0, lat;
    logic [7:0] exp;
    d0 = done_count; lat = 0;
    vin = 8'h3C; cmp_mode = 0;
    exp_q.push_back(8'h3C);
    start = 1'b1;
    @(negedge clk);
    for (int n = 1; n <= 200; n++) begin
      start = (n % 2 == 0);
      if (done === 1'b1) begin
        start = 1'b1;
        lat = n;
        break;
      end
      @(negedge clk);
    end
    compared++;
    if (lat != L8) begin mismatched++; $display("[TB] FAIL busy_start_latency: got %0d expected %0d", lat, L8); end
    exp = exp_q.pop_front();
    compared++;
    if (result !== exp) begin mismatched++; $display("[TB] FAIL busy_start_result: got %h expected %h", result, exp); end
    @(negedge clk);
    start = 1'b0;
    repeat (40) @(negedge clk);
    compared++;
    if (done_count - d0 != 1) begin mismatched++; $display("[TB] FAIL busy_start_done_count: got %0d expected 1", done_count - d0); end
  endtask

  task automatic test_back_to_back();
    int lat, gap;
    logic [7:0] exp;
    lat = 0; gap = 0;
    vin = 8'h01; cmp_mode = 0;
    exp_q.push_back(8'h01);
    exp_q.push_back(8'hFE);
    start = 1'b1;
    @(negedge clk);
    for (int n = 1; n <= 200; n++) begin
      if (done === 1'b1) begin lat = n; break; end
      @(negedge clk);
    end
    compared++;
    if (lat != L8) begin mismatched++; $display("[TB] FAIL b2b_first_latency: got %0d expected %0d", lat, L8); end
    exp = exp_q.pop_front();
    compared++;
    if (result !== exp) begin mismatched++; $display("[TB] FAIL b2b_first_result: got %h expected %h", result, exp); end
    vin = 8'hFE;
    for (int n = 1; n <= 200; n++) begin
      @(negedge clk);
      if (done === 1'b1) begin gap = n; break; end
    end
    start = 1'b0;
    compared++;
    if (gap != L8 + 1) begin mismatched++; $display("[TB] FAIL b2b_gap: got %0d expected %0d", gap, L8 + 1); end
    exp = exp_q.pop_front();
    compared++;
    if (result !== exp) begin mismatched++; $display("[TB] FAIL b2b_second_result: got %h expected %h", result, exp); end
    repeat (5) @(negedge clk);
    compared++;
    if (busy !== 1'b0) begin mismatched++; $display("[TB] FAIL b2b_idle_after: got busy %b expected 0", busy); end
  endtask

  task automatic test_reset_mid();
    int lat, busy_n, sample_n;
    logic [7:0] exp;
    vin = 8'h77; cmp_mode = 0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (11) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    compared++;
    if ({sample, busy, done} !== 3'b000 || dac_code !== 8'h00) begin mismatched++; $display("[TB] FAIL midreset_outputs: got s%b b%b d%b dac %h expected all 0", sample, busy, done, dac_code); end
    compared++;
    if (result !== 8'h00) begin mismatched++; $display("[TB] FAIL midreset_result: got %h expected 00", result); end
    rst = 1'b0;
    @(negedge clk);
    exp_q.push_back(8'h5A);
    run_conv(8'h5A, 0, lat, busy_n, sample_n);
    compared++;
    if (lat != L8) begin mismatched++; $display("[TB] FAIL midreset_latency: got %0d expected %0d", lat, L8); end
    exp = exp_q.pop_front();
    compared++;
    if (result !== exp) begin mismatched++; $display("[TB] FAIL midreset_result_after: got %h expected %h", result, exp); end
    @(negedge clk);
  endtask

  task automatic test_small_width();
    int lat;
    logic [7:0] exp;
    lat = 0;
    vin_s = 4'h9;
    exp_q.push_back(8'h09);
    start_s = 1'b1;
    @(negedge clk);
    start_s = 1'b0;
    for (int n = 1; n <= 200; n++) begin
      if (done_s === 1'b1) begin lat = n; break; end
      @(negedge clk);
    end
    compared++;
    if (lat != L4) begin mismatched++; $display("[TB] FAIL small_latency: got %0d expected %0d", lat, L4); end
    exp = exp_q.pop_front();
    compared++;
    if ({4'h0, result_s} !== exp) begin mismatched++; $display("[TB] FAIL small_result: got %h expected %h", result_s, exp); end
    @(negedge clk);
  endtask

  // Test sequence
  initial begin
    rst = 1'b1; start = 1'b0; start_s = 1'b0;
    vin = 8'h00; vin_s = 4'h0; cmp_mode = 0;
    test_reset();
    test_ideal(8'hA5);
    test_tied(1, 8'hFF);
    test_tied(2, 8'h00);
    test_start_during_busy();
    test_back_to_back();
    test_reset_mid();
    test_small_width();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
